// File: rtl/chiptune_uart_tx_if.sv
// rtl/chiptune_uart_tx_if.sv - request, register bytes and serial status of the chiptune UART sender
interface chiptune_uart_tx_if;
   logic       start;
   logic [7:0] reg_4000;
   logic [7:0] reg_4001;
   logic [7:0] reg_4002;
   logic [7:0] reg_4003;
   logic       tx;
   logic       busy;
   logic       done;

   modport master (
      output start, reg_4000, reg_4001, reg_4002, reg_4003,
      input  tx, busy, done
   );

   modport slave (
      input  start, reg_4000, reg_4001, reg_4002, reg_4003,
      output tx, busy, done
   );
endinterface

// File: rtl/chiptune_uart_tx.sv
// rtl/chiptune_uart_tx.sv - 8N1 sender for one four-byte APU pulse-channel register message
module chiptune_uart_tx #(
   parameter int CLKRATE  = 1_790_000,
   parameter int BAUDRATE = 9600,
   parameter int GAP_BITS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   chiptune_uart_tx_if.slave bus
);
   localparam int DIVISOR = CLKRATE / BAUDRATE;
   localparam int BW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int GW      = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_GAP
   } state_t;

   state_t        state, state_nxt;
   logic [BW-1:0] baud_cnt, baud_cnt_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [1:0]    byte_idx, byte_idx_nxt;
   logic [GW-1:0] gap_cnt, gap_cnt_nxt;
   logic [31:0]   snap, snap_nxt;
   logic          tx_q, tx_nxt;
   logic          busy_q, busy_nxt;
   logic          done_q, done_nxt;
   logic [7:0]    cur_byte;
   logic          baud_tick;
   logic          accept;

   assign baud_tick = (baud_cnt == BAUD_LAST);
   assign accept    = bus.start && !busy_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         gap_cnt  <= '0;
         snap     <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         byte_idx <= byte_idx_nxt;
         gap_cnt  <= gap_cnt_nxt;
         snap     <= snap_nxt;
         tx_q     <= tx_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      baud_cnt_nxt = baud_tick ? '0 : baud_cnt + 1'b1;
      bit_idx_nxt  = bit_idx;
      byte_idx_nxt = byte_idx;
      gap_cnt_nxt  = gap_cnt;
      snap_nxt     = snap;
      case (state)
         S_IDLE: begin
            // Counter restarts at acceptance so the first start bit is full length
            baud_cnt_nxt = '0;
            if (accept) begin
               state_nxt    = S_START;
               snap_nxt     = {bus.reg_4003, bus.reg_4002, bus.reg_4001, bus.reg_4000};
               bit_idx_nxt  = '0;
               byte_idx_nxt = '0;
               gap_cnt_nxt  = '0;
            end
         end
         S_START: begin
            if (baud_tick) begin
               state_nxt   = S_DATA;
               bit_idx_nxt = '0;
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (baud_tick) begin
               if (byte_idx == 2'd3) begin
                  state_nxt   = S_GAP;
                  gap_cnt_nxt = '0;
               end else begin
                  state_nxt    = S_START;
                  byte_idx_nxt = byte_idx + 2'd1;
               end
            end
         end
         S_GAP: begin
            if (baud_tick) begin
               if (gap_cnt == GAP_LAST) begin
                  state_nxt    = S_IDLE;
                  byte_idx_nxt = '0;
                  gap_cnt_nxt  = '0;
               end else begin
                  gap_cnt_nxt = gap_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so the flops present the new level on the same edge
   always_comb begin
      cur_byte = snap_nxt[8*byte_idx_nxt +: 8];
      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state == S_GAP) && (state_nxt == S_IDLE);
      tx_nxt   = 1'b1;
      case (state_nxt)
         S_START: tx_nxt = 1'b0;
         S_DATA:  tx_nxt = cur_byte[bit_idx_nxt];
         default: tx_nxt = 1'b1;
      endcase
   end

   assign bus.tx   = tx_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_chiptune_uart_tx.sv
// tb/tb_chiptune_uart_tx.sv - randomized self-checking bench for chiptune_uart_tx
module tb_chiptune_uart_tx;
   localparam int CLKRATE  = 96_000;
   localparam int BAUDRATE = 9600;
   localparam int GAP_BITS = 2;
   localparam int DIV      = CLKRATE / BAUDRATE;
   localparam int TOTAL    = (40 + GAP_BITS) * DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   fall_cyc;
   int   done_cyc;
   logic exp_wave [TOTAL];
   logic cap      [TOTAL];

   chiptune_uart_tx_if bus ();

   chiptune_uart_tx #(
      .CLKRATE (CLKRATE),
      .BAUDRATE(BAUDRATE),
      .GAP_BITS(GAP_BITS)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_regs(input logic [31:0] msg);
      bus.reg_4000 = msg[7:0];
      bus.reg_4001 = msg[15:8];
      bus.reg_4002 = msg[23:16];
      bus.reg_4003 = msg[31:24];
   endtask

   // Line level per bit period: per byte a low start, eight data bits LSB first, a high stop; then the gap
   function automatic void build_expected(input logic [31:0] msg);
      for (int p = 0; p < 40 + GAP_BITS; p++) begin
         int   b;
         int   pos;
         logic lvl;
         b   = p / 10;
         pos = p % 10;
         if (p >= 40)       lvl = 1'b1;
         else if (pos == 0) lvl = 1'b0;
         else if (pos == 9) lvl = 1'b1;
         else               lvl = msg[8*b + pos - 1];
         for (int c = 0; c < DIV; c++) exp_wave[p*DIV + c] = lvl;
      end
   endfunction

   // Leaves the bench sampled in the done cycle so a caller can chain another start immediately
   task automatic send_message(input logic [31:0] msg, input int inject_at, input logic [31:0] junk);
      int bad_tx;
      int bad_busy;
      int dones;
      build_expected(msg);
      drive_regs(msg);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      drive_regs($urandom());
      fall_cyc = cyc;
      checks++;
      if (bus.tx !== 1'b0 || bus.busy !== 1'b1)
         $display("FAIL accept_latency: tx=%b busy=%b, required tx=0 busy=1", bus.tx, bus.busy);
      bad_tx = 0;
      bad_busy = 0;
      dones = 0;
      for (int n = 0; n < TOTAL; n++) begin
         if (n > 0) tick();
         cap[n] = bus.tx;
         if (bus.tx !== exp_wave[n]) bad_tx++;
         if (bus.busy !== 1'b1) bad_busy++;
         if (bus.done !== 1'b0) dones++;
         if (n == inject_at) begin
            bus.start = 1'b1;
            drive_regs(junk);
         end else begin
            bus.start = 1'b0;
         end
      end
      if (bad_tx != 0 || bad_busy != 0 || dones != 0) errors++;
      checks++;
      if (bad_tx != 0)
         $display("FAIL tx_wave: %0d cycles differ from model, required 0", bad_tx);
      if (bad_busy != 0)
         $display("FAIL busy_len: %0d of %0d cycles not busy, required 0", bad_busy, TOTAL);
      if (dones != 0)
         $display("FAIL early_done: %0d done pulses while busy, required 0", dones);
      for (int b = 0; b < 4; b++) begin
         int         base;
         logic [7:0] got;
         logic       frame_ok;
         base = b * 10 * DIV;
         for (int i = 0; i < 8; i++) got[i] = cap[base + (1 + i)*DIV + DIV/2];
         frame_ok = (cap[base + DIV/2] == 1'b0) && (cap[base + 9*DIV + DIV/2] == 1'b1);
         checks++;
         if (got !== msg[8*b +: 8] || !frame_ok) begin
            errors++;
            $display("FAIL uart_byte%0d: got %02h frame_ok=%b, required %02h frame_ok=1",
                     b, got, frame_ok, msg[8*b +: 8]);
         end
      end
      tick();
      done_cyc = cyc;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.tx !== 1'b1) begin
         errors++;
         $display("FAIL completion: busy=%b done=%b tx=%b, required busy=0 done=1 tx=1",
                  bus.busy, bus.done, bus.tx);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      drive_regs(32'h0);
      repeat (3) tick();
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: tx=%b busy=%b done=%b, required 1/0/0", bus.tx, bus.busy, bus.done);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      int bad;
      bad = 0;
      for (int n = 0; n < 1000; n++) begin
         tick();
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL idle_stable: %0d disturbed cycles, required 0", bad);
      end
   endtask

   task automatic test_single();
      send_message(32'hF8FD08BF, -1, 32'h0);
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL done_width: done=%b busy=%b, required 0/0", bus.done, bus.busy);
      end
      for (int r = 0; r < 3; r++) begin
         send_message($urandom(), -1, 32'h0);
         repeat ($urandom_range(1, 7)) tick();
      end
   endtask

   task automatic test_bit_width();
      int run_len [8];
      int exp_len [8];
      int nruns;
      int len;
      exp_len = '{90, 10, 90, 10, 90, 10, 90, 10 + GAP_BITS*DIV};
      send_message(32'h0, -1, 32'h0);
      tick();
      nruns = 0;
      len = 1;
      for (int n = 1; n <= TOTAL; n++) begin
         if (n == TOTAL || cap[n] !== cap[n-1]) begin
            if (nruns < 8) run_len[nruns] = len;
            nruns++;
            len = 1;
         end else begin
            len++;
         end
      end
      checks++;
      if (nruns != 8) begin
         errors++;
         $display("FAIL run_count: %0d runs, required 8", nruns);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (run_len[i] != exp_len[i] || (run_len[i] % DIV) != 0) begin
               errors++;
               $display("FAIL run_len%0d: %0d clocks, required %0d", i, run_len[i], exp_len[i]);
            end
         end
      end
   endtask

   task automatic test_start_while_busy();
      int stray;
      send_message(32'hF8FD08BF, 100, 32'h44332211);
      stray = 0;
      for (int n = 0; n < 3*DIV; n++) begin
         tick();
         if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tx !== 1'b1) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL ignored_start: %0d active cycles after completion, required 0", stray);
      end
   endtask

   task automatic test_back_to_back();
      int f1;
      int d1;
      send_message($urandom(), -1, 32'h0);
      f1 = fall_cyc;
      d1 = done_cyc;
      send_message($urandom(), -1, 32'h0);
      checks++;
      if (d1 - (f1 + 40*DIV) != GAP_BITS*DIV) begin
         errors++;
         $display("FAIL gap_len: %0d clocks, required %0d", d1 - (f1 + 40*DIV), GAP_BITS*DIV);
      end
      checks++;
      if (fall_cyc - d1 != 1) begin
         errors++;
         $display("FAIL chain_start: start bit %0d clocks after done, required 1", fall_cyc - d1);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int bad;
      drive_regs($urandom());
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (24*DIV) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: tx=%b busy=%b done=%b, required 1/0/0", bus.tx, bus.busy, bus.done);
      end
      bad = 0;
      for (int n = 0; n < TOTAL + 80; n++) begin
         tick();
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL post_reset_quiet: %0d active cycles, required 0", bad);
      end
      send_message($urandom(), -1, 32'h0);
      tick();
   endtask

   initial begin
      bus.start = 1'b0;
      drive_regs(32'h0);
      test_reset();
      test_idle();
      test_single();
      test_bit_width();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
